loopback_checker: RTL and testbench
===================================

# loopback_checker

Testbench-side agent for the ConnectTB one-net link. It connects through the `tb` modport, serializes a WIDTH-bit pattern LSB-first onto `drive`, and samples `observe` after a programmable pipeline latency. It rebuilds the captured word and counts per-bit mismatches against the pattern. It sits in the test harness opposite the DUT, which consumes the `dut` modport.

## Interface
Parameters:
- WIDTH, default 8: pattern length in bits; must be ≥ 1.
- MAX_LAT, default 4: largest supported DUT latency in cycles.

Ports:
- clk  input  1  single clock; everything is sampled on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- intf  interface  —  ConnectTB.tb modport. `drive` is the registered output; `observe` is sampled input.
- start  input  1  run request; accepted only in IDLE.
- pattern  input  WIDTH  word to transmit; latched on accept.
- latency  input  $clog2(MAX_LAT+1)  cycles from drive to observe; latched on accept. Values above MAX_LAT are clamped to MAX_LAT.
- busy  output  1  high from the accept edge until DONE is entered.
- done  output  1  one-cycle completion pulse.
- captured  output  WIDTH  reconstructed word; held until the next accept.
- err_count  output  $clog2(WIDTH+1)  number of mismatching bits; held until the next accept.
- pass  output  1  registered (err_count == 0); updated on entry to DONE.

## Operation
- States: IDLE, SHIFT, DRAIN, DONE.
- IDLE → SHIFT when start=1:
  - latch pattern and the clamped latency (Lq);
  - drive <= pattern[0];
  - tx index = 0, sample counter = 0;
  - clear captured and err_count;
  - busy <= 1.
- SHIFT, cycle c (c = 0 is the first cycle after the accept edge):
  - drive = pattern[c];
  - at each edge, tx index increments; after index WIDTH-1, drive <= 0 and the FSM goes to DRAIN. If Lq = 0, it goes directly to DONE.
- Sampling runs in SHIFT and DRAIN:
  - at the edge ending cycle c, with c ≥ Lq, sample `observe` into captured[c-Lq];
  - increment err_count if `observe` ≠ pattern[c-Lq].
- DRAIN → DONE at the edge that captures bit WIDTH-1, i.e. the edge ending cycle WIDTH-1+Lq.
- DONE lasts one cycle: done=1, busy=0, pass valid. The FSM then returns to IDLE unconditionally.
- start is ignored outside IDLE; pattern and latency changes during a run have no effect.
- Simultaneous events: start arriving in the DONE cycle is ignored. It is accepted on the first IDLE cycle.

## Timing
- Reset values: state IDLE, drive 0, busy 0, done 0, captured 0, err_count 0, pass 0.
- Reset mid-run aborts immediately to these values. No done pulse is produced.
- All outputs are registered; there is no combinational path from observe to any output.
- Accept-to-done: done is high in cycle WIDTH+Lq, counting the cycle after the accept edge as cycle 0.
- Minimum start-to-start spacing: WIDTH+Lq+2 cycles.
- Before a run, `drive` rests at 0. A DUT with latency greater than Lq therefore shifts zeros into the low captured bits.
- err_count cannot overflow: it is at most WIDTH.

## Structure
- Shared package loopback_pkg holds:
  - typedef enum loopback_state_e {IDLE, SHIFT, DRAIN, DONE};
  - default constants LB_WIDTH_DEF = 8 and LB_MAX_LAT_DEF = 4.
- Single module, no sub-modules. The counters, capture shift logic and FSM are small enough to live inline.

## Test plan
All cases use WIDTH=8 and MAX_LAT=4.
- Direct SUB wire (0 latency), latency=0, pattern 8'hA5 → drive shows 1,0,1,0,0,1,0,1 on cycles 0..7; done in cycle 8; captured=8'hA5; err_count=0; pass=1.
- DUT model with a 2-flop delay, latency=2, pattern 8'h3C → done in cycle 10; captured=8'h3C; err_count=0.
- 2-flop delay DUT, latency=1, pattern 8'hA5 → captured=8'h4A; err_count=7; pass=0.
- latency=7 (clamped to 4) with a 4-flop delay DUT, pattern 8'hFF → done in cycle 12; captured=8'hFF; err_count=0.
- start pulsed again in cycle 3 with pattern 8'h00 → ignored; the run completes with the original pattern's result; busy stays high throughout.
- rst_n asserted low in cycle 4 → drive, busy, done, captured, err_count and pass are all 0 asynchronously. No done pulse follows. A fresh start after release runs normally.

Source files
------------

// File: rtl/loopback_pkg.sv
// loopback_pkg: shared state encoding and default sizing for the loopback checker.
// Rev 1.0
`default_nettype none

package loopback_pkg;

  localparam int LB_WIDTH_DEF   = 8;
  localparam int LB_MAX_LAT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } loopback_state_e;

endpackage

`default_nettype wire

// File: rtl/connect_tb_if.sv
// ConnectTB: one-net link between the testbench agent (tb) and the device under test (dut).
// Rev 1.0
`default_nettype none

interface ConnectTB;
  logic drive;
  logic observe;

  modport tb  (output drive, input  observe);
  modport dut (input  drive, output observe);
endinterface

`default_nettype wire

// File: rtl/loopback_checker.sv
// loopback_checker: serializes a pattern LSB-first onto the link, recaptures it after a
// programmable latency and counts bit mismatches. Rev 1.0
`default_nettype none

module loopback_checker
  import loopback_pkg::*;
#(
  parameter int WIDTH   = LB_WIDTH_DEF,
  parameter int MAX_LAT = LB_MAX_LAT_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  ConnectTB.tb                         intf,
  input  logic                         start,
  input  logic [WIDTH-1:0]             pattern,
  input  logic [$clog2(MAX_LAT+1)-1:0] latency,
  output logic                         busy,
  output logic                         done,
  output logic [WIDTH-1:0]             captured,
  output logic [$clog2(WIDTH+1)-1:0]   err_count,
  output logic                         pass
);

  localparam int LW = $clog2(MAX_LAT + 1);
  localparam int EW = $clog2(WIDTH + 1);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = $clog2(WIDTH + MAX_LAT + 1);

  loopback_state_e  state_q;
  logic [WIDTH-1:0] pat_q;
  logic [LW-1:0]    lat_q;
  logic             drive_q;
  logic [IW-1:0]    idx_q;
  logic [CW-1:0]    cyc_q;
  logic [WIDTH-1:0] captured_q;
  logic [EW-1:0]    err_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;

  logic [LW-1:0]    lat_clamp_d;
  logic             w_sample;
  logic [CW-1:0]    w_sdiff;
  logic [IW-1:0]    w_sidx;
  logic             w_last;
  logic             w_miss;
  logic [EW-1:0]    err_d;
  logic             w_tx_last;
  logic [IW-1:0]    idx_d;

  assign lat_clamp_d = (latency > LW'(MAX_LAT)) ? LW'(MAX_LAT) : latency;

  // cyc_q counts cycles since accept; bit (cyc_q - lat_q) is on observe once cyc_q >= lat_q.
  assign w_sample  = (cyc_q >= CW'(lat_q));
  assign w_sdiff   = cyc_q - CW'(lat_q);
  assign w_sidx    = w_sdiff[IW-1:0];
  assign w_last    = w_sample && (w_sdiff == CW'(WIDTH - 1));
  assign w_miss    = w_sample && (intf.observe != pat_q[w_sidx]);
  assign err_d     = err_q + EW'(w_miss);
  assign w_tx_last = (idx_q == IW'(WIDTH - 1));
  assign idx_d     = idx_q + IW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pat_q      <= '0;
      lat_q      <= '0;
      drive_q    <= 1'b0;
      idx_q      <= '0;
      cyc_q      <= '0;
      captured_q <= '0;
      err_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            pat_q      <= pattern;
            lat_q      <= lat_clamp_d;
            drive_q    <= pattern[0];
            idx_q      <= '0;
            cyc_q      <= '0;
            captured_q <= '0;
            err_q      <= '0;
            busy_q     <= 1'b1;
            state_q    <= SHIFT;
          end
        end
        SHIFT, DRAIN: begin
          cyc_q <= cyc_q + CW'(1);
          if (w_sample) begin
            captured_q[w_sidx] <= intf.observe;
            err_q              <= err_d;
          end
          if (state_q == SHIFT) begin
            if (w_tx_last) begin
              drive_q <= 1'b0;
              state_q <= DRAIN;
            end else begin
              idx_q   <= idx_d;
              drive_q <= pat_q[idx_d];
            end
          end
          // With zero latency the final capture coincides with the final transmit bit.
          if (w_last) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign intf.drive = drive_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign captured   = captured_q;
  assign err_count  = err_q;
  assign pass       = pass_q;

endmodule

`default_nettype wire

// File: tb/tb_loopback_checker.sv
// tb_loopback_checker: randomized runs against a cycle-level behavioural model of the agent,
// with a configurable-delay DUT stand-in on the link. Rev 1.0
`default_nettype none

module tb_loopback_checker;

  localparam int W  = 8;
  localparam int ML = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] pattern = 8'h00;
  logic [2:0] latency = 3'd0;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] captured;
  logic [3:0] err_count;

  ConnectTB link();

  loopback_checker #(.WIDTH(W), .MAX_LAT(ML)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .intf      (link),
    .start     (start),
    .pattern   (pattern),
    .latency   (latency),
    .busy      (busy),
    .done      (done),
    .captured  (captured),
    .err_count (err_count),
    .pass      (pass)
  );

  always #5 clk = ~clk;

  // DUT stand-in: observe is drive delayed by dut_d flops (0 = straight wire).
  int         dut_d = 0;
  logic [3:0] dl = 4'h0;
  always @(posedge clk) dl <= {dl[2:0], link.drive};
  assign link.observe = (dut_d == 0) ? link.drive : dl[dut_d-1];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_t = cycles since the accept edge (-1 when not running); a run spans cycles 0..W+L.
  int         m_t = -1;
  int         m_lat = 0;
  int         m_d = 0;
  logic [7:0] m_pat = 8'h00;
  logic [7:0] m_cap = 8'h00;
  int         m_err = 0;
  logic       m_pass = 1'b0;

  function automatic logic ideal_drive(input logic [7:0] p, input int t);
    return (t >= 0 && t < W) ? p[t] : 1'b0;
  endfunction

  function automatic logic [7:0] exp_cap(input logic [7:0] p, input int l, input int d);
    logic [7:0] c;
    c = 8'h00;
    for (int k = 0; k < W; k++) c[k] = ideal_drive(p, k + l - d);
    return c;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t    <= -1;
      m_cap  <= 8'h00;
      m_err  <= 0;
      m_pass <= 1'b0;
    end else if (m_t < 0) begin
      if (start) begin
        m_t   <= 0;
        m_pat <= pattern;
        m_lat <= (int'(latency) > ML) ? ML : int'(latency);
        m_d   <= dut_d;
        m_cap <= 8'h00;
        m_err <= 0;
      end
    end else if (m_t == W + m_lat) begin
      m_t <= -1;
    end else begin
      m_t <= m_t + 1;
      if (m_t + 1 == W + m_lat) begin
        m_cap  <= exp_cap(m_pat, m_lat, m_d);
        m_err  <= $countones(exp_cap(m_pat, m_lat, m_d) ^ m_pat);
        m_pass <= ($countones(exp_cap(m_pat, m_lat, m_d) ^ m_pat) == 0);
      end
    end
  end

  always @(negedge clk) begin
    logic e_busy;
    logic e_done;
    e_busy = (m_t >= 0) && (m_t < W + m_lat);
    e_done = (m_t >= 0) && (m_t == W + m_lat);
    check("busy", busy, e_busy);
    check("done", done, e_done);
    check("drive", link.drive, (m_t >= 0) ? ideal_drive(m_pat, m_t) : 1'b0);
    check("pass", pass, m_pass);
    if (!e_busy) begin
      check("captured", captured, m_cap);
      check("err_count", err_count, m_err);
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_run(input logic [7:0] p, input logic [2:0] l, input int d,
                        input int poke, output int dc);
    dut_d = d;
    repeat (6) @(negedge clk);
    pattern = p;
    latency = l;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    pattern = 8'($urandom);
    latency = 3'($urandom);
    dc = -1;
    for (int c = 0; c < 40; c++) begin
      if (done) begin
        dc = c;
        break;
      end
      if (c == poke) begin
        start   = 1'b1;
        pattern = 8'h00;
      end
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  int dc;
  int nd;
  int first_done;
  int n_done;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_captured", captured, 8'h00);
    check("rst_err", err_count, 4'd0);
    check("rst_pass", pass, 1'b0);
    check("rst_drive", link.drive, 1'b0);
    rst_n = 1'b1;

    do_run(8'hA5, 3'd0, 0, -1, dc);
    check("a5_l0_done_cyc", dc, 8);
    check("a5_l0_cap", captured, 8'hA5);
    check("a5_l0_err", err_count, 4'd0);
    check("a5_l0_pass", pass, 1'b1);

    do_run(8'h3C, 3'd2, 2, -1, dc);
    check("3c_l2_done_cyc", dc, 10);
    check("3c_l2_cap", captured, 8'h3C);
    check("3c_l2_err", err_count, 4'd0);

    do_run(8'hA5, 3'd1, 2, -1, dc);
    check("a5_l1_cap", captured, 8'h4A);
    check("a5_l1_err", err_count, 4'd7);
    check("a5_l1_pass", pass, 1'b0);

    do_run(8'hFF, 3'd7, 4, -1, dc);
    check("ff_clamp_done_cyc", dc, 12);
    check("ff_clamp_cap", captured, 8'hFF);
    check("ff_clamp_err", err_count, 4'd0);

    do_run(8'hC3, 3'd1, 1, 3, dc);
    check("restart_done_cyc", dc, 9);
    check("restart_cap", captured, 8'hC3);
    check("restart_err", err_count, 4'd0);

    // Reset in the middle of a run.
    dut_d = 2;
    repeat (6) @(negedge clk);
    pattern = 8'h96;
    latency = 3'd2;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_captured", captured, 8'h00);
    check("arst_err", err_count, 4'd0);
    check("arst_pass", pass, 1'b0);
    check("arst_drive", link.drive, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    nd = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("arst_no_done", nd, 0);
    do_run(8'h96, 3'd2, 2, -1, dc);
    check("post_rst_done_cyc", dc, 10);
    check("post_rst_cap", captured, 8'h96);

    // start held high: the second accept lands on the first IDLE cycle after DONE.
    dut_d = 1;
    repeat (6) @(negedge clk);
    pattern = 8'h5B;
    latency = 3'd1;
    start   = 1'b1;
    first_done = -1;
    n_done = 0;
    for (int c = 0; c < 60 && n_done < 2; c++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        if (n_done == 1) first_done = c;
        else check("b2b_spacing", c - first_done, W + 1 + 2);
      end
    end
    start = 1'b0;
    check("b2b_two_runs", n_done, 2);
    check("b2b_cap", captured, 8'h5B);

    for (int r = 0; r < 16; r++) begin
      logic [2:0] l;
      int         poke;
      l    = 3'($urandom_range(0, 7));
      poke = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, W + 3)) : -1;
      do_run(8'($urandom), l, int'($urandom_range(0, 4)), poke, dc);
      check("rand_done_cyc", dc, W + ((int'(l) > ML) ? ML : int'(l)));
    end

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
